// File: rtl/pulse_period_monitor.sv
// Edge-to-edge period monitor with lock/err/timeout; registered outputs one clock after the edge, no backpressure.
// Define PULSE_MON_SYNC_EN to add a 2-flop pulse_in synchronizer (+2 clocks on every edge-relative event).
module pulse_period_monitor #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 3,
  parameter int TIMEOUT    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic [WIDTH-1:0] exp_period,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int               CW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0]    LOCK_C  = CW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] TO_C    = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] GAP_MAX = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  state_t           state, state_n;
  logic             pulse_s;
  logic             prev;
  logic             pulse_edge;
  logic [WIDTH-1:0] gap, gap_n;
  logic [CW-1:0]    match_cnt, match_n, match_inc;
  logic [WIDTH-1:0] period_n;
  logic             pv_n, locked_n, err_n, to_n;
  logic             match, timed_out;

`ifdef PULSE_MON_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], pulse_in};
  end

  assign pulse_s = sync_q[1];
`else
  assign pulse_s = pulse_in;
`endif

  assign pulse_edge = pulse_s & ~prev;
  // A zero expected period is treated as "don't know", never a match.
  assign match      = (exp_period != '0) && (gap == exp_period);
  assign match_inc  = match_cnt + CW'(1);
  assign timed_out  = !pulse_edge && (gap == TO_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prev         <= 1'b0;
      gap          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      prev         <= pulse_s;
      gap          <= gap_n;
      match_cnt    <= match_n;
      period       <= period_n;
      period_valid <= pv_n;
      locked       <= locked_n;
      err          <= err_n;
      timeout      <= to_n;
    end
  end

  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    period_n = period;
    pv_n     = 1'b0;
    locked_n = locked;
    err_n    = 1'b0;
    to_n     = 1'b0;

    if (pulse_edge)          gap_n = WIDTH'(1);
    else if (gap == GAP_MAX) gap_n = gap;
    else                     gap_n = gap + WIDTH'(1);

    case (state)
      IDLE: begin
        // First edge only opens the measurement window.
        if (pulse_edge) state_n = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (pulse_edge) begin
          period_n = gap;
          pv_n     = 1'b1;
          if (match) begin
            if (state == MEASURE) begin
              match_n = match_inc;
              if (match_inc == LOCK_C) begin
                state_n  = LOCKED;
                locked_n = 1'b1;
              end
            end
          end else begin
            match_n = '0;
            if (state == LOCKED) begin
              err_n    = 1'b1;
              locked_n = 1'b0;
              state_n  = MEASURE;
            end
          end
        end else if (timed_out) begin
          to_n     = 1'b1;
          locked_n = 1'b0;
          match_n  = '0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
Receive-side companion to the periodic pulse generator. Detects rising edges on a pulse train in the same clock domain and measures the interval between consecutive edges in clocks. Compares each interval against an expected period and reports lock, mismatch and loss-of-pulse. Sits at the consumer end of any counter/compare pulse source, e.g. a 5-clock strobe, and is used as a self-checking monitor.

Parameters:
WIDTH, 8, width of interval counter, period and exp_period
LOCK_COUNT, 3, consecutive matching periods required to assert locked (>=1)
TIMEOUT, 32, clocks without an edge (in MEASURE/LOCKED) before declaring loss; must be < 2^WIDTH

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
pulse_in  input  1  pulse train, synchronous to clk
exp_period  input  WIDTH  expected edge-to-edge interval in clocks, sampled at each edge
period  output  WIDTH  last measured interval, held until next measurement
period_valid  output  1  1-cycle strobe: period updated this cycle
locked  output  1  level: LOCK_COUNT consecutive matches seen, no mismatch since
err  output  1  1-cycle strobe: mismatch while LOCKED
timeout  output  1  1-cycle strobe: no edge for TIMEOUT clocks

Behaviour:
- All outputs are registered. Reset values: period=0, period_valid=0, locked=0, err=0, timeout=0; state=IDLE, gap=0, match_cnt=0, prev=0.
- Edge detect: prev <= pulse_in each clock; edge = pulse_in & ~prev. A level held high yields exactly one edge.
- gap counter: loads 1 on an edge cycle; otherwise increments, saturating at 2^WIDTH-1.
- States: IDLE, MEASURE, LOCKED.
- IDLE: edge -> MEASURE, gap<=1. No period_valid is generated on the first edge.
- MEASURE/LOCKED, edge: period<=gap, period_valid<=1 on the same edge. Example: edges at cycles n and n+5 give period=5.
- Match rule: gap==exp_period. exp_period=0 never matches.
- MEASURE, match: match_cnt<=match_cnt+1. When the new value equals LOCK_COUNT -> LOCKED and locked<=1 on the same edge.
- MEASURE, mismatch: match_cnt<=0, stay in MEASURE.
- LOCKED, match: stay; match_cnt saturates at LOCK_COUNT.
- LOCKED, mismatch: err<=1 for one cycle, locked<=0, match_cnt<=0 -> MEASURE. The mismatching period is still reported with period_valid.
- Timeout: state!=IDLE, no edge this cycle, and gap==TIMEOUT. Result: timeout<=1 for one cycle, locked<=0, match_cnt<=0 -> IDLE. The next edge is treated as a first edge.
- Priority: an edge always beats timeout on the same cycle. In IDLE, gap keeps counting (saturating) but never times out.
- Asynchronous reset mid-operation: all outputs drop on the reset assertion edge, not at the next clk. The first edge after release is a first edge.
- exp_period may change at any time. Only the value present on an edge cycle is used.

Optional Feature:
PULSE_MON_SYNC_EN
- Defined: pulse_in passes through a 2-flop synchronizer (reset to 0) before edge detect. This allows an asynchronous pulse_in. All edge-relative events occur 2 clocks later; measured periods are unchanged.
- Undefined: pulse_in feeds edge detect directly, with zero added latency.

Test Plan:
- Generator with period 5, 1-clk pulses, exp_period=5 -> period_valid at edges 2,3,4 with period=5; locked rises on the edge-4 cycle; err=0.
- Locked at period 5, then one interval of 7 clocks -> period=7 with period_valid; err 1-cycle pulse and locked=0 on that edge; locked returns 3 matching periods later.
- Locked, then pulse_in stuck low -> timeout strobe exactly 32 clocks after the last edge; locked=0, state IDLE; the next edge gives no period_valid.
- pulse_in held high for 20 clocks after one edge -> only one edge detected; no period_valid; timeout at TIMEOUT.
- Reset asserted asynchronously mid-period while locked -> locked/period/strobes are 0 immediately. After release, the first edge gives no period_valid and the second edge gives the correct period.
- exp_period=0 with a period-5 train -> period=5 reported every edge; locked never asserts; err never pulses.
